object_qualifier: RTL and testbench

OBJECT_QUALIFIER -- requirements
Module: object_qualifier

---
 rtl/object_qualifier_pkg.sv | 37 +++
 rtl/object_qualifier_pixel_match_counter.sv | 25 ++
 rtl/object_qualifier.sv | 131 +++++++++++++
 tb/tb_object_qualifier.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/object_qualifier_pkg.sv
// Shared definitions for the object qualifier: FSM state encoding,
// default widths and the hit-streak update rule.
package object_qualifier_pkg;

    // Default pixel counter width, wide enough for a full 640x480 frame.
    localparam int CNT_W_DEFAULT = 19;

    // Width of the consecutive-hit-frame counter (FRAMES_REQ is at most 7).
    localparam int STREAK_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2,
        FOUND = 2'd3
    } qual_state_t;

    // Next hit streak after evaluating a frame: a hit extends the streak,
    // saturating at the required frame count; a miss restarts it.
    function automatic logic [STREAK_W-1:0] streak_after_eval(
        input logic [STREAK_W-1:0] streak,
        input logic                hit,
        input logic [STREAK_W-1:0] frames_req
    );
        logic [STREAK_W-1:0] result;
        result = '0;
        if (hit) begin
            if (streak >= frames_req) begin
                result = frames_req;
            end else begin
                result = streak + 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/object_qualifier_pixel_match_counter.sv
// Saturating counter of matched pixels within one frame.
module pixel_match_counter #(
    parameter int CNT_W = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Clear has priority over increment; the count sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/object_qualifier.sv
// Qualifies a colour-matched object over consecutive camera frames and
// raises a latched object_found once enough hit frames in a row are seen.
module object_qualifier
    import object_qualifier_pkg::*;
#(
    parameter int MATCH_THRESH = 2000,
    parameter int FRAMES_REQ   = 3,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic                clock_50,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                frame_end,
    input  logic                pixel_valid,
    input  logic                pixel_match,
    input  logic                clear,
    output logic                object_found,
    output logic                frame_done,
    output logic [CNT_W-1:0]    match_count,
    output logic [STREAK_W-1:0] hit_streak
);

    localparam logic [STREAK_W-1:0] FRAMES_REQ_L = STREAK_W'(FRAMES_REQ);
    localparam logic [31:0]         THRESH_U     = 32'(MATCH_THRESH);

    qual_state_t         state_reg;
    logic [STREAK_W-1:0] hit_streak_reg;
    logic [STREAK_W-1:0] hit_streak_next;
    logic [CNT_W-1:0]    match_count_reg;
    logic                object_found_reg;
    logic                frame_done_reg;

    logic                cnt_clr;
    logic                cnt_inc;
    logic [CNT_W-1:0]    pix_count;
    logic [31:0]         pix_count_ext;
    logic                frame_hit;

    // Counter control: a frame_start that opens a frame (from IDLE) or aborts
    // one (in ACCUM without frame_end) zeroes the count; matches only count
    // while accumulating. clear abandons the frame, so it suppresses both.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (!clear) begin
            if (state_reg == IDLE) begin
                cnt_clr = frame_start;
            end else if (state_reg == ACCUM) begin
                cnt_clr = frame_start && !frame_end;
                cnt_inc = pixel_valid && pixel_match;
            end
        end
    end

    pixel_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock (clock_50),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (pix_count)
    );

    // Frame hit decision and the streak it produces, compared at 32 bits so
    // a threshold wider than the counter simply never hits.
    always_comb begin
        pix_count_ext   = 32'(pix_count);
        frame_hit       = (pix_count_ext >= THRESH_U);
        hit_streak_next = streak_after_eval(hit_streak_reg, frame_hit, FRAMES_REQ_L);
    end

    // Qualification FSM with registered outputs; clear outranks frame events,
    // reset outranks everything.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_reg        <= IDLE;
            hit_streak_reg   <= '0;
            match_count_reg  <= '0;
            object_found_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (clear) begin
                state_reg        <= IDLE;
                hit_streak_reg   <= '0;
                object_found_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (frame_start) begin
                            state_reg <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (frame_end) begin
                            state_reg <= EVAL;
                        end else if (frame_start) begin
                            // Aborted frame: the streak no longer describes
                            // consecutive frames, so it restarts.
                            hit_streak_reg <= '0;
                        end
                    end
                    EVAL: begin
                        frame_done_reg  <= 1'b1;
                        match_count_reg <= pix_count;
                        hit_streak_reg  <= hit_streak_next;
                        if (hit_streak_next == FRAMES_REQ_L) begin
                            state_reg        <= FOUND;
                            object_found_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    FOUND: begin
                        object_found_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign object_found = object_found_reg;
    assign frame_done   = frame_done_reg;
    assign match_count  = match_count_reg;
    assign hit_streak   = hit_streak_reg;

endmodule

// File: tb/tb_object_qualifier.sv
// Randomised scoreboard bench for object_qualifier (THRESH=10, FRAMES=3, CNT_W=8).
module tb_object_qualifier;

    localparam int THRESH = 10;
    localparam int FRAMES = 3;
    localparam int CW     = 8;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clock_50 = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          frame_end = 1'b0;
    logic          pixel_valid = 1'b0;
    logic          pixel_match = 1'b0;
    logic          clear = 1'b0;
    logic          object_found;
    logic          frame_done;
    logic [CW-1:0] match_count;
    logic [2:0]    hit_streak;

    object_qualifier #(
        .MATCH_THRESH (THRESH),
        .FRAMES_REQ   (FRAMES),
        .CNT_W        (CW)
    ) dut (
        .clock_50     (clock_50),
        .reset        (reset),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .pixel_valid  (pixel_valid),
        .pixel_match  (pixel_match),
        .clear        (clear),
        .object_found (object_found),
        .frame_done   (frame_done),
        .match_count  (match_count),
        .hit_streak   (hit_streak)
    );

    always #10 clock_50 = ~clock_50;

    typedef struct {
        int mc;
        int hs;
        int of;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model state: streak of hit frames, latched detection,
    // and whether a frame has been opened but not closed.
    int   m_streak = 0;
    bit   m_found  = 1'b0;
    bit   m_open   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock_50);
        #1;
    endtask

    // Monitor: every frame_done pulse is matched against the oldest expectation.
    always @(negedge clock_50) begin
        if (!reset && frame_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("match_count", int'(match_count), e.mc);
                check("hit_streak", int'(hit_streak), e.hs);
                check("object_found", int'(object_found), e.of);
                $display("frame: match_count=%0d hit_streak=%0d object_found=%0d",
                         match_count, hit_streak, object_found);
            end
        end
    end

    // Open a frame, place some matches, and leave it without a frame_end.
    task automatic open_frame(input int n_match);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (!m_found) begin
            if (m_open) m_streak = 0;
            m_open = 1'b1;
        end
        for (int i = 0; i < n_match; i++) begin
            pixel_valid = 1'b1;
            pixel_match = 1'b1;
            step();
        end
        pixel_valid = 1'b0;
        pixel_match = 1'b0;
    endtask

    // Full frame with n_match counted matches plus ignorable noise pixels.
    task automatic run_frame(input int n_match);
        bit  last_on_end;
        bit  was_found;
        int  cnt;
        exp_t e;
        was_found = m_found;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (!was_found) begin
            if (m_open) m_streak = 0;
            check("streak_after_start", int'(hit_streak), m_streak);
        end
        last_on_end = (n_match > 0) && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < n_match - int'(last_on_end); i++) begin
            case ($urandom_range(0, 3))
                0: begin pixel_valid = 1'b1; pixel_match = 1'b0; step(); end
                1: begin pixel_valid = 1'b0; pixel_match = 1'b1; step(); end
                default: ;
            endcase
            pixel_valid = 1'b1;
            pixel_match = 1'b1;
            step();
        end
        frame_end   = 1'b1;
        pixel_valid = last_on_end;
        pixel_match = last_on_end;
        step();
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        pixel_match = 1'b0;
        if (!was_found) begin
            cnt      = (n_match > CMAX) ? CMAX : n_match;
            m_streak = (cnt >= THRESH) ? ((m_streak >= FRAMES) ? FRAMES : m_streak + 1) : 0;
            m_found  = (m_streak == FRAMES);
            m_open   = 1'b0;
            e.mc = cnt;
            e.hs = m_streak;
            e.of = int'(m_found);
            exp_q.push_back(e);
        end
        check("frame_done_eval_cycle", int'(frame_done), 0);
        check("found_eval_cycle", int'(object_found), int'(was_found));
        step();
        check("frame_done_latency", int'(frame_done), int'(!was_found));
        check("found_latency", int'(object_found), int'(m_found));
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        if ($urandom_range(0, 1) == 1) frame_start = 1'b1;
        step();
        clear = 1'b0;
        frame_start = 1'b0;
        m_streak = 0;
        m_found  = 1'b0;
        m_open   = 1'b0;
        check("clear_found", int'(object_found), 0);
        check("clear_streak", int'(hit_streak), 0);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_streak = 0;
        m_found  = 1'b0;
        m_open   = 1'b0;
        check("rst_found", int'(object_found), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_streak", int'(hit_streak), 0);
    endtask

    initial begin
        repeat (3) step();
        do_reset();

        // Three hit frames in a row -> detection two cycles after the last end.
        run_frame(12);
        run_frame(12);
        run_frame(12);
        // Frames while detected are ignored.
        run_frame(15);
        do_clear();

        // Hit, miss, hit.
        run_frame(12);
        run_frame(9);
        run_frame(12);
        do_clear();

        // Saturation: 300 matches read back as 255 and count as a hit.
        run_frame(300);
        do_clear();

        // Two hits, then an aborted frame restarts the streak.
        run_frame(12);
        run_frame(12);
        open_frame(5);
        run_frame(12);
        run_frame(12);
        run_frame(12);
        do_clear();

        // Reset mid-frame, then matches in IDLE must not count.
        open_frame(7);
        do_reset();
        pixel_valid = 1'b1;
        pixel_match = 1'b1;
        repeat (4) step();
        pixel_valid = 1'b0;
        pixel_match = 1'b0;
        run_frame(3);

        // Randomised mix of frames, aborts and clears.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0:       open_frame($urandom_range(0, 12));
                1:       do_clear();
                2:       run_frame($urandom_range(250, 300));
                default: run_frame($urandom_range(6, 16));
            endcase
        end

        repeat (4) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
